// File: rtl/ps2_line_assembler.sv
// PS/2 set-2 scan codes to ASCII, editing a 32-character line and committing it on Enter.
// Define PS2_SHIFT_EN for lowercase letters with shift-key case and symbol handling.
module ps2_line_assembler #(
    parameter int unsigned LINE_CHARS = 32
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [7:0]   scan_code,
    input  logic         scan_valid,
    output logic [255:0] edit_content,
    output logic [5:0]   edit_len,
    output logic [255:0] line_content,
    output logic         line_ready
);

    localparam logic [5:0] MaxLen = 6'(LINE_CHARS);

    typedef enum logic [1:0] {StNorm, StBrk, StExt, StExtBrk} state_e;

    state_e         state_q, state_d;
    logic [255:0]   edit_q, edit_d;
    logic [5:0]     len_q, len_d;
    logic [255:0]   line_q, line_d;
    logic           ready_q, ready_d;
    logic [7:0]     ascii;
    logic           do_commit;
    logic [5:0]     bs_idx;
    logic [4:0]     wr_pos, bs_pos;

    // Returns uppercase/base ASCII, or 0x00 for an unmapped code.
    function automatic logic [7:0] key_base(input logic [7:0] code);
        unique case (code)
            8'h1C: key_base = "A";  8'h32: key_base = "B";  8'h21: key_base = "C";
            8'h23: key_base = "D";  8'h24: key_base = "E";  8'h2B: key_base = "F";
            8'h34: key_base = "G";  8'h33: key_base = "H";  8'h43: key_base = "I";
            8'h3B: key_base = "J";  8'h42: key_base = "K";  8'h4B: key_base = "L";
            8'h3A: key_base = "M";  8'h31: key_base = "N";  8'h44: key_base = "O";
            8'h4D: key_base = "P";  8'h15: key_base = "Q";  8'h2D: key_base = "R";
            8'h1B: key_base = "S";  8'h2C: key_base = "T";  8'h3C: key_base = "U";
            8'h2A: key_base = "V";  8'h1D: key_base = "W";  8'h22: key_base = "X";
            8'h35: key_base = "Y";  8'h1A: key_base = "Z";
            8'h45: key_base = "0";  8'h16: key_base = "1";  8'h1E: key_base = "2";
            8'h26: key_base = "3";  8'h25: key_base = "4";  8'h2E: key_base = "5";
            8'h36: key_base = "6";  8'h3D: key_base = "7";  8'h3E: key_base = "8";
            8'h46: key_base = "9";
            8'h29: key_base = " ";  8'h41: key_base = ",";  8'h49: key_base = ".";
            8'h4E: key_base = "-";  8'h4A: key_base = "/";
            default: key_base = 8'h00;
        endcase
    endfunction

`ifdef PS2_SHIFT_EN
    logic shift_l_q, shift_l_d, shift_r_q, shift_r_d;

    function automatic logic [7:0] key_shifted(input logic [7:0] b);
        unique case (b)
            "1": key_shifted = "!";  "2": key_shifted = "@";  "3": key_shifted = "#";
            "4": key_shifted = "$";  "5": key_shifted = "%";  "6": key_shifted = "^";
            "7": key_shifted = "&";  "8": key_shifted = "*";  "9": key_shifted = "(";
            "0": key_shifted = ")";  ",": key_shifted = "<";  ".": key_shifted = ">";
            "-": key_shifted = "_";  "/": key_shifted = "?";
            default: key_shifted = b;
        endcase
    endfunction

    always_comb begin
        ascii = key_base(scan_code);
        if (ascii >= "A" && ascii <= "Z") begin
            if (!(shift_l_q || shift_r_q)) ascii = ascii | 8'h20;
        end else if (shift_l_q || shift_r_q) begin
            ascii = key_shifted(ascii);
        end
    end
`else
    always_comb ascii = key_base(scan_code);
`endif

    assign wr_pos = 5'd31 - len_q[4:0];
    assign bs_idx = len_q - 6'd1;
    assign bs_pos = 5'd31 - bs_idx[4:0];

    always_comb begin
        state_d   = state_q;
        edit_d    = edit_q;
        len_d     = len_q;
        line_d    = line_q;
        ready_d   = 1'b0;
        do_commit = 1'b0;
`ifdef PS2_SHIFT_EN
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
`endif
        if (scan_valid) begin
            unique case (state_q)
                StNorm: begin
                    if (scan_code == 8'hF0) begin
                        state_d = StBrk;
                    end else if (scan_code == 8'hE0) begin
                        state_d = StExt;
                    end else if (scan_code == 8'h5A) begin
                        do_commit = 1'b1;
                    end else if (scan_code == 8'h66) begin
                        if (len_q != 6'd0) begin
                            len_d = bs_idx;
                            edit_d[{bs_pos, 3'b000} +: 8] = 8'h00;
                        end
`ifdef PS2_SHIFT_EN
                    end else if (scan_code == 8'h12) begin
                        shift_l_d = 1'b1;
                    end else if (scan_code == 8'h59) begin
                        shift_r_d = 1'b1;
`endif
                    end else if (ascii != 8'h00 && len_q < MaxLen) begin
                        edit_d[{wr_pos, 3'b000} +: 8] = ascii;
                        len_d = len_q + 6'd1;
                    end
                end
                StBrk: begin
`ifdef PS2_SHIFT_EN
                    if (scan_code == 8'h12) shift_l_d = 1'b0;
                    if (scan_code == 8'h59) shift_r_d = 1'b0;
`endif
                    state_d = StNorm;
                end
                StExt: begin
                    if (scan_code == 8'hF0) begin
                        state_d = StExtBrk;
                    end else begin
                        do_commit = (scan_code == 8'h5A);
                        state_d   = StNorm;
                    end
                end
                StExtBrk: state_d = StNorm;
                default:  state_d = StNorm;
            endcase
        end
        if (do_commit) begin
            line_d  = edit_q;
            ready_d = 1'b1;
            edit_d  = '0;
            len_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StNorm;
            edit_q    <= '0;
            len_q     <= '0;
            line_q    <= '0;
            ready_q   <= 1'b0;
`ifdef PS2_SHIFT_EN
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            edit_q    <= edit_d;
            len_q     <= len_d;
            line_q    <= line_d;
            ready_q   <= ready_d;
`ifdef PS2_SHIFT_EN
            shift_l_q <= shift_l_d;
            shift_r_q <= shift_r_d;
`endif
        end
    end

    assign edit_content = edit_q;
    assign edit_len     = len_q;
    assign line_content = line_q;
    assign line_ready   = ready_q;

endmodule
